trigger_qualifier: RTL and testbench
====================================

Name: trigger_qualifier

Overview:
- Upstream stage of the glitch generator.
- Conditions the raw target-side event line: synchronizes it, deglitches it, and counts qualifying edges.
- Produces the level `trigger` the glitch generator consumes.
- Holds `trigger` high until the generator reports done, then releases it so the generator returns to READY.
- Runs on the same 204 MHz PLL clock as the generator.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on raw_in (legal 2..4).
- FILTER_COUNT, 16'd8, consecutive cycles a new level must persist before acceptance; 0 = no filtering.
- EDGE_COUNT, 8'd1, qualifying edges required after arm before firing; 0 is treated as 1.
- EDGE_POL, 1'b1, 1 = rising edges qualify, 0 = falling edges qualify.
- HOLD_TIMEOUT, 32'd2_000_000, maximum FIRE duration in cycles; used only with the optional feature.

Ports:
- clk  input  1  PLL clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- arm  input  1  one-cycle request to arm; honoured only in IDLE.
- abort  input  1  returns ARMED to IDLE; ignored in other states.
- raw_in  input  1  asynchronous event line from the target.
- done_in  input  1  done indicator from the glitch generator.
- trigger  output  1  to the glitch generator trigger input; registered.
- armed  output  1  high while in ARMED; registered.
- edge_cnt  output  8  qualifying edges seen since arm.
- timed_out  output  1  sticky timeout flag (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - Sync chain, filtered level, filter counter, edge_cnt and all outputs go to 0.
  - Reset during any state, including FIRE, drops trigger on the next cycle.
- Synchronizer: SYNC_STAGES flops in series; no logic between them.
- Filter:
  - Counter increments while the synchronized level differs from the filtered level.
  - Counter clears on any cycle where they agree.
  - When the counter reaches FILTER_COUNT, the filtered level takes the new value and the counter clears.
  - FILTER_COUNT=0: filtered level equals the synchronized level, delayed one flop.
  - Counter is 16 bits and saturates; it does not wrap.
- Edge detect: one-cycle registered pulse when the filtered level transitions in the EDGE_POL direction.
- FSM states: IDLE, ARMED, FIRE, RELEASE.
  - IDLE: trigger=0. arm=1 and abort=0 → ARMED, edge_cnt cleared. Simultaneous arm and abort → stays IDLE.
  - ARMED: armed=1.
    - Qualifying edge → edge_cnt+1; if the new count ≥ max(EDGE_COUNT,1) → FIRE.
    - abort → IDLE, edge_cnt retained for readback.
    - abort coincident with the final edge → abort wins.
    - edge_cnt saturates at 255.
  - FIRE: trigger=1. done_in=1 → RELEASE. arm and abort are ignored.
  - RELEASE: trigger=0. done_in=0 → IDLE.
- Edges arriving outside ARMED are discarded, not counted.
- Latency: if raw_in rises and stays stable, trigger goes high exactly SYNC_STAGES+FILTER_COUNT+2 cycles after the first clk edge that samples raw_in high. This applies to the final qualifying edge with EDGE_POL=1.
- Pulses on raw_in shorter than FILTER_COUNT synchronized cycles produce no edge.
- done_in already high on FIRE entry → RELEASE on the next cycle; trigger is high for exactly 1 cycle.
- arm held high continuously: re-arms on every IDLE entry. This is intended, for repeated glitch campaigns.

Optional Feature:
- Macro: TRIGGER_QUALIFIER_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in FIRE.
  - If done_in has not risen after HOLD_TIMEOUT cycles → IDLE directly, trigger drops, and timed_out is set.
  - timed_out clears on the next accepted arm or on rst.
  - The counter clears on FIRE entry.
- Undefined:
  - FIRE waits indefinitely for done_in.
  - timed_out is tied 0.
  - No timeout counter is synthesized.
  - Port list is identical either way.

Decomposition:
- Shared package glitch_pkg holds:
  - FSM state encoding constants (IDLE=0, ARMED=1, FIRE=2, RELEASE=3, 2 bits);
  - counter width constants (FILTER_W=16, EDGE_W=8, TIMEOUT_W=32).
- These are reusable by the glitch generator's own FSM.
- One natural sub-module, trig_filter: synchronizer, filter and edge-pulse generator. Parameters SYNC_STAGES, FILTER_COUNT, EDGE_POL; output is the 1-cycle edge pulse.
- The FSM, counters and timeout stay in trigger_qualifier.

Test Plan:
- rst, arm, raw_in 0→1 held, defaults → trigger high exactly 12 cycles after raw_in is sampled high; armed drops the same cycle; edge_cnt=1.
- raw_in 5-cycle high pulse with FILTER_COUNT=8 → no edge; edge_cnt stays 0; state stays ARMED.
- EDGE_COUNT=3, three clean rising edges → edge_cnt goes 1,2,3; trigger only after the third; falling edges do not count.
- FIRE, done_in high at cycle 200 then low at 210 → trigger falls at 201; IDLE entered at 211; a new arm is accepted at 212.
- abort coincident with the final qualifying edge → IDLE, trigger never asserts. Reset mid-FIRE → trigger 0 the next cycle, all outputs 0.
- With TRIGGER_QUALIFIER_TIMEOUT_EN and HOLD_TIMEOUT=100, done_in held 0 → trigger high for exactly 100 cycles, then 0 with timed_out=1; next arm clears timed_out.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared encodings for the glitch path: FSM state codes and counter widths.
// Used by trigger_qualifier and reusable by the glitch generator FSM.
package glitch_pkg;

    localparam int FILTER_W  = 16;
    localparam int EDGE_W    = 8;
    localparam int TIMEOUT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_RELEASE = 2'd3
    } qual_state_t;

    // Saturating increment for the qualifying-edge counter.
    function automatic logic [EDGE_W-1:0] edge_inc(
        input logic [EDGE_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trig_filter.sv
// Synchronizer, persistence filter and edge-pulse generator for raw_in.
// Ports: clk, rst (sync, high), raw_in (async), edge_pulse (1-cycle, registered).
module trig_filter
    import glitch_pkg::*;
#(
    parameter int                  SYNC_STAGES  = 2,
    parameter logic [FILTER_W-1:0] FILTER_COUNT = 16'd8,
    parameter logic                EDGE_POL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTER_W-1:0]    cnt_q;
    logic                   filt_q;
    logic                   filt_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Plain shift chain; nothing may sit between the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // A new level is accepted on the cycle after the counter has
    // reached FILTER_COUNT, so it must persist FILTER_COUNT+1 samples
    // at the filter input; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (FILTER_COUNT == '0) begin
            filt_q <= sync_lvl;
            cnt_q  <= '0;
        end else if (sync_lvl == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q >= FILTER_COUNT) begin
            filt_q <= sync_lvl;
            cnt_q  <= '0;
        end else if (cnt_q != '1) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_d     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            filt_d     <= filt_q;
            edge_pulse <= EDGE_POL ? (filt_q & ~filt_d)
                                   : (~filt_q & filt_d);
        end
    end

endmodule

// File: rtl/trigger_qualifier.sv
// Qualifies target events into a level trigger held until the glitch
// generator reports done. Optional FIRE timeout: TRIGGER_QUALIFIER_TIMEOUT_EN.
// Ports: clk, rst (sync, high), arm, abort, raw_in, done_in ->
//        trigger, armed, edge_cnt[7:0], timed_out (sticky; 0 without macro).
module trigger_qualifier
    import glitch_pkg::*;
#(
    parameter int                   SYNC_STAGES  = 2,
    parameter logic [FILTER_W-1:0]  FILTER_COUNT = 16'd8,
    parameter logic [EDGE_W-1:0]    EDGE_COUNT   = 8'd1,
    parameter logic                 EDGE_POL     = 1'b1,
    parameter logic [TIMEOUT_W-1:0] HOLD_TIMEOUT = 32'd2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             raw_in,
    input  logic             done_in,
    output logic             trigger,
    output logic             armed,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic             timed_out
);

    localparam logic [EDGE_W-1:0] EDGE_TARGET =
        (EDGE_COUNT == '0) ? 8'd1 : EDGE_COUNT;

    qual_state_t      state;
    logic             edge_pulse;
    logic [EDGE_W-1:0] edge_cnt_inc;

    assign edge_cnt_inc = edge_inc(edge_cnt);

    trig_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_COUNT (FILTER_COUNT),
        .EDGE_POL     (EDGE_POL)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .edge_pulse (edge_pulse)
    );

`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 to_hit;
    logic                 timed_out_q;

    // Expires on the HOLD_TIMEOUT-th FIRE cycle without done_in.
    assign to_hit    = ({1'b0, to_cnt} + 33'd1) >= {1'b0, HOLD_TIMEOUT};
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            trigger  <= 1'b0;
            armed    <= 1'b0;
            edge_cnt <= '0;
`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
            to_cnt      <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    trigger <= 1'b0;
                    if (arm && !abort) begin
                        state    <= ST_ARMED;
                        armed    <= 1'b1;
                        edge_cnt <= '0;
`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
                        timed_out_q <= 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    // abort beats a coincident final edge
                    if (abort) begin
                        state <= ST_IDLE;
                        armed <= 1'b0;
                    end else if (edge_pulse) begin
                        edge_cnt <= edge_cnt_inc;
                        if (edge_cnt_inc >= EDGE_TARGET) begin
                            state   <= ST_FIRE;
                            armed   <= 1'b0;
                            trigger <= 1'b1;
`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                        end
                    end
                end
                ST_FIRE: begin
                    if (done_in) begin
                        state   <= ST_RELEASE;
                        trigger <= 1'b0;
`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
                    end else if (to_hit) begin
                        state       <= ST_IDLE;
                        trigger     <= 1'b0;
                        timed_out_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    trigger <= 1'b0;
                    if (!done_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    trigger <= 1'b0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_qualifier.sv
// Directed bench for trigger_qualifier: default instance plus an
// EDGE_COUNT=3 instance; timeout checks follow TRIGGER_QUALIFIER_TIMEOUT_EN.
module tb_trigger_qualifier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       raw_in = 1'b0;
    logic       done_in = 1'b0;
    logic       trigger;
    logic       armed;
    logic [7:0] edge_cnt;
    logic       timed_out;

    logic       arm3 = 1'b0;
    logic       abort3 = 1'b0;
    logic       raw3 = 1'b0;
    logic       done3 = 1'b0;
    logic       trigger3;
    logic       armed3;
    logic [7:0] edge_cnt3;
    logic       timed_out3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trigger_qualifier #(
        .HOLD_TIMEOUT (32'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .raw_in    (raw_in),
        .done_in   (done_in),
        .trigger   (trigger),
        .armed     (armed),
        .edge_cnt  (edge_cnt),
        .timed_out (timed_out)
    );

    trigger_qualifier #(
        .EDGE_COUNT (8'd3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm3),
        .abort     (abort3),
        .raw_in    (raw3),
        .done_in   (done3),
        .trigger   (trigger3),
        .armed     (armed3),
        .edge_cnt  (edge_cnt3),
        .timed_out (timed_out3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        checks++;
        if ({trigger, armed, edge_cnt, timed_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got trig=%b armed=%b cnt=%0d to=%b, want all 0",
                     trigger, armed, edge_cnt, timed_out);
        end
        checks++;
        if ({trigger3, armed3, edge_cnt3} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs3: got trig=%b armed=%b cnt=%0d, want all 0",
                     trigger3, armed3, edge_cnt3);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        bit early;
        bit armed_late;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        raw_in = 1'b1;
        checks++;
        if (armed !== 1'b1 || edge_cnt !== 8'd0) begin
            errors++;
            $display("FAIL arm_accept: got armed=%b cnt=%0d, want 1/0", armed, edge_cnt);
        end
        early = 0;
        armed_late = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (trigger !== 1'b0) early = 1;
            if (i == 11 && armed !== 1'b1) armed_late = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL latency_early: trigger high before 12 cycles, want 0");
        end
        checks++;
        if (armed_late) begin
            errors++;
            $display("FAIL armed_hold: armed=%b at cycle 11, want 1", armed);
        end
        tick();
        checks++;
        if (trigger !== 1'b1 || armed !== 1'b0 || edge_cnt !== 8'd1) begin
            errors++;
            $display("FAIL latency_fire: got trig=%b armed=%b cnt=%0d, want 1/0/1",
                     trigger, armed, edge_cnt);
        end
    endtask

    task automatic test_release();
        arm = 1'b1;
        abort = 1'b1;
        ticks(3);
        arm = 1'b0;
        abort = 1'b0;
        checks++;
        if (trigger !== 1'b1 || armed !== 1'b0) begin
            errors++;
            $display("FAIL fire_hold: got trig=%b armed=%b, want 1/0", trigger, armed);
        end
        done_in = 1'b1;
        tick();
        checks++;
        if (trigger !== 1'b0) begin
            errors++;
            $display("FAIL done_drop: got trig=%b, want 0", trigger);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL release_arm: got armed=%b, want 0", armed);
        end
        done_in = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1 || edge_cnt !== 8'd0 || trigger !== 1'b0) begin
            errors++;
            $display("FAIL rearm: got armed=%b cnt=%0d trig=%b, want 1/0/0",
                     armed, edge_cnt, trigger);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got armed=%b, want 0", armed);
        end
    endtask

    task automatic test_short_pulse();
        raw_in = 1'b0;
        ticks(15);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        raw_in = 1'b1;
        ticks(5);
        raw_in = 1'b0;
        ticks(20);
        checks++;
        if (edge_cnt !== 8'd0 || armed !== 1'b1 || trigger !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: got cnt=%0d armed=%b trig=%b, want 0/1/0",
                     edge_cnt, armed, trigger);
        end
    endtask

    task automatic test_abort_final();
        bit fired;
        raw_in = 1'b1;
        ticks(12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (armed !== 1'b0 || trigger !== 1'b0 || edge_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_final: got armed=%b trig=%b cnt=%0d, want 0/0/0",
                     armed, trigger, edge_cnt);
        end
        fired = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (trigger !== 1'b0) fired = 1;
        end
        checks++;
        if (fired) begin
            errors++;
            $display("FAIL abort_nofire: trigger rose after abort, want 0");
        end
    endtask

    task automatic test_edge_count();
        arm3 = 1'b1;
        tick();
        arm3 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            raw3 = 1'b1;
            ticks(14);
            checks++;
            if (edge_cnt3 !== 8'(k) || trigger3 !== 1'b0) begin
                errors++;
                $display("FAIL edge3_rise%0d: got cnt=%0d trig=%b, want %0d/0",
                         k, edge_cnt3, trigger3, k);
            end
            raw3 = 1'b0;
            ticks(14);
            checks++;
            if (edge_cnt3 !== 8'(k) || armed3 !== 1'b1) begin
                errors++;
                $display("FAIL edge3_fall%0d: got cnt=%0d armed=%b, want %0d/1",
                         k, edge_cnt3, armed3, k);
            end
        end
        done3 = 1'b1;
        raw3 = 1'b1;
        ticks(12);
        checks++;
        if (trigger3 !== 1'b0) begin
            errors++;
            $display("FAIL edge3_early: got trig=%b, want 0", trigger3);
        end
        tick();
        checks++;
        if (trigger3 !== 1'b1 || edge_cnt3 !== 8'd3 || armed3 !== 1'b0) begin
            errors++;
            $display("FAIL edge3_fire: got trig=%b cnt=%0d armed=%b, want 1/3/0",
                     trigger3, edge_cnt3, armed3);
        end
        tick();
        checks++;
        if (trigger3 !== 1'b0) begin
            errors++;
            $display("FAIL done_preset: got trig=%b, want 0 after 1 cycle", trigger3);
        end
        done3 = 1'b0;
        tick();
        arm3 = 1'b1;
        tick();
        arm3 = 1'b0;
        checks++;
        if (armed3 !== 1'b1 || edge_cnt3 !== 8'd0) begin
            errors++;
            $display("FAIL edge3_rearm: got armed=%b cnt=%0d, want 1/0", armed3, edge_cnt3);
        end
    endtask

    task automatic test_reset_fire();
        raw_in = 1'b0;
        ticks(15);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        raw_in = 1'b1;
        ticks(13);
        checks++;
        if (trigger !== 1'b1 || edge_cnt !== 8'd1) begin
            errors++;
            $display("FAIL refire: got trig=%b cnt=%0d, want 1/1", trigger, edge_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({trigger, armed, edge_cnt, timed_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_fire: got trig=%b armed=%b cnt=%0d to=%b, want all 0",
                     trigger, armed, edge_cnt, timed_out);
        end
    endtask

    task automatic test_timeout();
        bit dropped;
        ticks(15);
        checks++;
        if (armed !== 1'b0 || edge_cnt !== 8'd0 || trigger !== 1'b0) begin
            errors++;
            $display("FAIL idle_discard: got armed=%b cnt=%0d trig=%b, want 0/0/0",
                     armed, edge_cnt, trigger);
        end
`ifdef TRIGGER_QUALIFIER_TIMEOUT_EN
        raw_in = 1'b0;
        ticks(15);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        raw_in = 1'b1;
        ticks(13);
        dropped = (trigger !== 1'b1);
        for (int i = 0; i < 99; i++) begin
            tick();
            if (trigger !== 1'b1) dropped = 1;
        end
        checks++;
        if (dropped || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: trigger fell early or to=%b, want 100 cycles high",
                     timed_out);
        end
        tick();
        checks++;
        if (trigger !== 1'b0 || timed_out !== 1'b1 || armed !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got trig=%b to=%b armed=%b, want 0/1/0",
                     trigger, timed_out, armed);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (timed_out !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: got to=%b armed=%b, want 0/1", timed_out, armed);
        end
`else
        dropped = 0;
        done_in = 1'b0;
        raw_in = 1'b0;
        ticks(15);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        raw_in = 1'b1;
        ticks(13);
        for (int i = 0; i < 150; i++) begin
            tick();
            if (trigger !== 1'b1 || timed_out !== 1'b0) dropped = 1;
        end
        checks++;
        if (dropped) begin
            errors++;
            $display("FAIL no_timeout: got trig=%b to=%b, want 1/0 held", trigger, timed_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_release();
        test_short_pulse();
        test_abort_final();
        test_edge_count();
        test_reset_fire();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
